serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Serial frame transmitter. Drives the single-bit serial line that the team's bit-stream FSM receivers consume on their x_in input.
- Accepts a parallel word through a load/ready handshake and emits one frame, one bit per clock:
  - start bit
  - data bits, LSB first
  - optional parity bit
  - one or two stop bits
- Sits between a parallel producer and any serial-input FSM in the design.

Parameters:
WIDTH, 8, data word width in bits (legal range 2..16)
PARITY_EN, 1, 1 = parity bit inserted after the data bits, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WIDTH  word to transmit, sampled on the load handshake
load  input  1  request to start a frame
ready  output  1  1 = block is idle and will accept load
x_out  output  1  serial line, idles high
busy  output  1  1 while a frame is in progress
done  output  1  one-cycle pulse, high during the final stop bit

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All state, x_out, busy and done are registers cleared by reset.
- Values while reset=0:
  - state = IDLE
  - x_out = 1
  - busy = 0
  - done = 0
  - ready = 1 (ready is decoded from state == IDLE)
  - shift register and bit counter = 0
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: x_out = 1, busy = 0. On a rising edge with load = 1:
  - data_in is latched into the shift register.
  - The parity accumulator is preset to PARITY_ODD.
  - Next state is START.
  - If load = 0, the block stays in IDLE.
- START: one cycle, x_out = 0, busy = 1. Next state is DATA; the bit counter is cleared.
- DATA: WIDTH cycles. Each cycle:
  - x_out = shift register bit 0.
  - The parity accumulator XORs in that bit.
  - The shift register shifts right by one.
  - The counter increments.
  - After the bit at counter = WIDTH-1, next state is PARITY if PARITY_EN = 1, otherwise STOP.
- PARITY: one cycle, x_out = parity accumulator.
  - Even parity: XOR of all data bits.
  - Odd parity: its inverse.
  - Next state is STOP.
- STOP: STOP_BITS cycles, x_out = 1.
  - done = 1 during the last stop cycle only.
  - Then the block returns to IDLE.
- Latency:
  - The first start-bit cycle appears on x_out in the cycle immediately after the load edge.
  - Frame length = 1 + WIDTH + PARITY_EN + STOP_BITS cycles.
  - ready rises in the cycle after done. The minimum gap between frames is one IDLE cycle.
- load while not in IDLE is ignored: no queueing, and the frame in progress is unaffected. data_in changes after the load edge do not affect the frame.
- load held high continuously gives back-to-back frames separated by exactly one IDLE cycle.
- Reset asserted mid-frame: x_out goes to 1 immediately (asynchronously), the frame is abandoned, and no done pulse is produced. Operation resumes from IDLE after reset releases.
- Illegal STOP_BITS values (anything other than 1 or 2) are treated as 1.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, load=0 for 5 cycles -> x_out=1, ready=1, busy=0, done=0 throughout.
- Defaults (W=8, even parity, 1 stop), data_in=0xA5, load for one cycle:
  - x_out = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; parity bit is 0.
  - busy is high for those 11 cycles; done is high only in the 11th cycle; ready returns on the 12th.
- PARITY_ODD=1, data_in=0xFF -> x_out = 0,1,1,1,1,1,1,1,1,1,1; odd parity bit is 1.
- PARITY_EN=0, STOP_BITS=2, data_in=0x00 -> x_out = 0,0,0,0,0,0,0,0,0,1,1; done is high on the 11th cycle only.
- Ignored load: load 0x3C, pulse load again with 0xC3 during the DATA state -> the full 0x3C frame is sent, then IDLE; no second frame.
- Mid-frame reset: load 0xA5, assert reset during the 4th data bit -> x_out=1 immediately, no done pulse. After release, load 0x5A -> a correct 0x5A frame is sent.

Source files
------------

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter (start, data LSB first, optional parity, stop bits)
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous, active-low reset
//   data_in  parallel word, sampled when load is accepted in IDLE
//   load     request to start a frame (ignored unless ready)
//   ready    high while idle and able to accept load
//   x_out    serial line, idles high
//   busy     high for every cycle of a frame
//   done     one-cycle pulse during the final stop bit
module serial_frame_tx #(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             x_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Anything other than two stop bits falls back to one.
   localparam int         STOPS     = (STOP_BITS == 2) ? 2 : 1;
   localparam logic [4:0] LAST_DATA = 5'(WIDTH - 1);
   localparam logic [4:0] LAST_STOP = 5'(STOPS - 1);
   localparam logic       PAR_INIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
   localparam logic       ONE_STOP  = (STOPS == 1) ? 1'b1 : 1'b0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             x_out_q, x_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // x_out is registered, so each state computes the line value for the
   // cycle that follows it. The data bit is therefore fetched from the
   // shift register one cycle before it appears on the line.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      x_out_d = x_out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            x_out_d = 1'b1;
            busy_d  = 1'b0;
            if (load) begin
               shreg_d = data_in;
               par_d   = PAR_INIT;
               state_d = S_START;
               x_out_d = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_START: begin
            state_d = S_DATA;
            cnt_d   = 5'd0;
            x_out_d = shreg_q[0];
            par_d   = par_q ^ shreg_q[0];
            shreg_d = shreg_q >> 1;
         end

         S_DATA: begin
            if (cnt_q == LAST_DATA) begin
               cnt_d = 5'd0;
               if (PARITY_EN != 0) begin
                  state_d = S_PARITY;
                  x_out_d = par_q;
               end else begin
                  state_d = S_STOP;
                  x_out_d = 1'b1;
                  done_d  = ONE_STOP;
               end
            end else begin
               cnt_d   = cnt_q + 5'd1;
               x_out_d = shreg_q[0];
               par_d   = par_q ^ shreg_q[0];
               shreg_d = shreg_q >> 1;
            end
         end

         S_PARITY: begin
            state_d = S_STOP;
            cnt_d   = 5'd0;
            x_out_d = 1'b1;
            done_d  = ONE_STOP;
         end

         S_STOP: begin
            x_out_d = 1'b1;
            if (cnt_q == LAST_STOP) begin
               state_d = S_IDLE;
               cnt_d   = 5'd0;
               busy_d  = 1'b0;
            end else begin
               cnt_d  = cnt_q + 5'd1;
               done_d = ((cnt_q + 5'd1) == LAST_STOP);
            end
         end

         default: begin
            state_d = S_IDLE;
            x_out_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= 5'd0;
         par_q   <= 1'b0;
         x_out_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         x_out_q <= x_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ready = (state_q == S_IDLE);
   assign x_out = x_out_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - directed and randomized frame checks on three parameter sets
module tb_serial_frame_tx;

   localparam int NONE = -10;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] ld, rdy, xo, bsy, dn;
   logic [7:0] din [3];

   int total  = 0;
   int passed = 0;

   // Frame shape of each instance: parity enable, odd parity, stop bits.
   int pen   [3] = '{1, 1, 0};
   int pod   [3] = '{0, 1, 0};
   int nstop [3] = '{1, 1, 2};

   always #5 clock = ~clock;

   serial_frame_tx u0 (
      .clock(clock), .reset(reset), .data_in(din[0]), .load(ld[0]),
      .ready(rdy[0]), .x_out(xo[0]), .busy(bsy[0]), .done(dn[0])
   );

   serial_frame_tx #(.PARITY_ODD(1)) u1 (
      .clock(clock), .reset(reset), .data_in(din[1]), .load(ld[1]),
      .ready(rdy[1]), .x_out(xo[1]), .busy(bsy[1]), .done(dn[1])
   );

   serial_frame_tx #(.PARITY_EN(0), .STOP_BITS(2)) u2 (
      .clock(clock), .reset(reset), .data_in(din[2]), .load(ld[2]),
      .ready(rdy[2]), .x_out(xo[2]), .busy(bsy[2]), .done(dn[2])
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_x"}, {5'd0, xo}, 8'h07);
      chk({tag, "_rdy"}, {5'd0, rdy}, 8'h07);
      chk({tag, "_busy"}, {5'd0, bsy}, 8'h00);
      chk({tag, "_done"}, {5'd0, dn}, 8'h00);
   endtask

   // Presents data and pulses load; returns at the falling edge of the
   // first frame cycle (start bit). With hold=1 load is left asserted.
   task automatic start(input int idx, input logic [7:0] data, input bit hold);
      @(negedge clock);
      chk($sformatf("ready_before_load%0d", idx), {7'd0, rdy[idx]}, 8'h01);
      ld[idx]  = 1'b1;
      din[idx] = data;
      @(negedge clock);
      if (!hold) ld[idx] = 1'b0;
   endtask

   // Expected line sequence built straight from the frame definition.
   // Optionally pulses load (with other data) at frame cycle pulse_at.
   // Returns at the falling edge of the idle cycle after the frame.
   task automatic check_frame(input int idx, input logic [7:0] data,
                              input int pulse_at, input logic [7:0] pdata);
      logic bits[$];
      bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) bits.push_back(data[b]);
      if (pen[idx] != 0) bits.push_back((^data) ^ pod[idx][0]);
      for (int s = 0; s < nstop[idx]; s++) bits.push_back(1'b1);

      for (int i = 0; i < bits.size(); i++) begin
         chk($sformatf("x%0d_%0h[%0d]", idx, data, i), {7'd0, xo[idx]}, {7'd0, bits[i]});
         chk($sformatf("busy%0d[%0d]", idx, i), {7'd0, bsy[idx]}, 8'h01);
         chk($sformatf("done%0d[%0d]", idx, i), {7'd0, dn[idx]},
             (i == bits.size() - 1) ? 8'h01 : 8'h00);
         chk($sformatf("ready%0d[%0d]", idx, i), {7'd0, rdy[idx]}, 8'h00);
         if (i == pulse_at) begin
            ld[idx]  = 1'b1;
            din[idx] = pdata;
         end else if (i == pulse_at + 1) begin
            ld[idx] = 1'b0;
         end
         @(negedge clock);
      end
      chk($sformatf("after_ready%0d", idx), {7'd0, rdy[idx]}, 8'h01);
      chk($sformatf("after_busy%0d", idx), {7'd0, bsy[idx]}, 8'h00);
      chk($sformatf("after_x%0d", idx), {7'd0, xo[idx]}, 8'h01);
      chk($sformatf("after_done%0d", idx), {7'd0, dn[idx]}, 8'h00);
   endtask

   initial begin
      logic [7:0] d, d2;
      int idx;

      reset = 1'b0;
      ld    = 3'b000;
      for (int i = 0; i < 3; i++) din[i] = 8'h00;

      // Reset held, then idle with no load.
      repeat (3) @(negedge clock);
      chk_idle("in_reset");
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk_idle($sformatf("idle%0d", i));
      end

      // Directed frames from each parameter set.
      start(0, 8'hA5, 1'b0);
      check_frame(0, 8'hA5, NONE, 8'h00);
      start(1, 8'hFF, 1'b0);
      check_frame(1, 8'hFF, NONE, 8'h00);
      start(2, 8'h00, 1'b0);
      check_frame(2, 8'h00, NONE, 8'h00);

      // Load during the data bits is ignored; no second frame follows.
      start(0, 8'h3C, 1'b0);
      check_frame(0, 8'h3C, 3, 8'hC3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk_idle($sformatf("no_second%0d", i));
      end

      // Reset in the 4th data bit (bit 3 of 0xA5 is 0 on the line).
      start(0, 8'hA5, 1'b0);
      repeat (4) @(negedge clock);
      chk("mid_x_before_reset", {7'd0, xo[0]}, 8'h00);
      reset = 1'b0;
      #1;
      chk("mid_x_async", {7'd0, xo[0]}, 8'h01);
      chk("mid_busy_async", {7'd0, bsy[0]}, 8'h00);
      chk("mid_ready_async", {7'd0, rdy[0]}, 8'h01);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         chk($sformatf("mid_done%0d", i), {7'd0, dn[0]}, 8'h00);
      end
      reset = 1'b1;
      start(0, 8'h5A, 1'b0);
      check_frame(0, 8'h5A, NONE, 8'h00);

      // Load held high: frames separated by exactly one idle cycle.
      d  = 8'($urandom);
      d2 = 8'($urandom);
      start(0, d, 1'b1);
      check_frame(0, d, NONE, 8'h00);
      din[0] = d2;
      @(negedge clock);
      check_frame(0, d2, NONE, 8'h00);
      ld[0] = 1'b0;

      // Randomized words across all three parameter sets.
      for (int r = 0; r < 9; r++) begin
         idx = r % 3;
         d   = 8'($urandom);
         start(idx, d, 1'b0);
         check_frame(idx, d, NONE, 8'h00);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
